// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader: sizes, state encoding
// and the session-length rule.
package im_pkg;

  localparam int          IM_WORDS       = 256;
  localparam logic [31:0] IM_BASE        = 32'h0000_3000;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          ADDR_W         = 8;
  localparam int          LEN_W          = 9;
  localparam int          BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ld_state_e;

  // A session must load at least one word and no more than the memory holds.
  function automatic logic len_valid(input logic [LEN_W-1:0] len, input int max_words);
    return (len != '0) && (int'(len) <= max_words);
  endfunction

endpackage

// File: rtl/im_word_packer.sv
// Collects host bytes big-endian into 32-bit words and keeps a running XOR
// checksum over every byte it is given.
module im_word_packer
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ld_n,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        word_full_o
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;

  // Flags the byte that completes the current word (combinational, for the FSM).
  assign word_full_o = byte_en_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;
  assign csum_o      = csum_q;

  // Next-state: clear at session start, otherwise shift a new byte in at the bottom.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
      csum_d = '0;
    end else if (byte_en_i) begin
      cnt_d  = cnt_q + BCNT_W'(1);
      word_d = {word_q[23:0], byte_i};
      csum_d = csum_q ^ byte_i;
    end
  end

  // Packing and checksum registers.
  always_ff @(posedge clk or negedge rst_ld_n) begin
    if (!rst_ld_n) begin
      cnt_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Host-to-instruction-memory loader: receives a length-prefixed byte stream,
// writes packed words to the IM, verifies a trailing XOR checksum and holds
// the CPU in reset until a session completes cleanly.
module im_loader
  import im_pkg::*;
#(
  parameter int IM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_ld_n,
  input  logic              ld_start,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  ld_state_e          state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
  logic               err_q, err_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               ready_q, busy_q, we_q;

  logic               xfer;
  logic               pk_clear, pk_en, pk_full;
  logic [31:0]        pk_word;
  logic [7:0]         pk_csum;

  assign xfer = ld_byte_valid && ld_byte_ready;

  im_word_packer u_packer (
    .clk         (clk),
    .rst_ld_n    (rst_ld_n),
    .clear_i     (pk_clear),
    .byte_en_i   (pk_en),
    .byte_i      (ld_byte),
    .word_o      (pk_word),
    .csum_o      (pk_csum),
    .word_full_o (pk_full)
  );

  // Next-state and session bookkeeping; outputs are registered from these.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    err_d      = err_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = 1'b0;
    pk_clear   = 1'b0;
    pk_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          if (len_valid(ld_len, IM_WORDS)) begin
            state_d    = ST_RECV;
            len_d      = ld_len;
            word_idx_d = '0;
            err_d      = 1'b0;
            cpu_rst_d  = 1'b1;
            pk_clear   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (xfer) begin
          pk_en = 1'b1;
          if (pk_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The index only advances when another word follows, so it stops at len-1.
        if ({1'b0, word_idx_q} == (len_q - LEN_W'(1))) begin
          state_d = ST_CHECK;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = ST_RECV;
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          if (ld_byte == pk_csum) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; ready/busy/we reflect the state being entered.
  always_ff @(posedge clk or negedge rst_ld_n) begin
    if (!rst_ld_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      ready_q    <= (state_d == ST_RECV) || (state_d == ST_CHECK);
      busy_q     <= (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
      we_q       <= (state_d == ST_WRITE);
    end
  end

  assign ld_byte_ready = ready_q;
  assign ld_busy       = busy_q;
  assign im_we         = we_q;
  assign im_waddr      = word_idx_q;
  assign im_wdata      = pk_word;
  assign cpu_rst       = cpu_rst_q;
  assign ld_done       = done_q;
  assign ld_err        = err_q;

endmodule
